// File: rtl/cache_port_arb.sv
// cache_port_arb
// Two-requester arbiter in front of a single cache controller port.
// The instruction-fetch unit (IFU, read only) and the load/store unit (LSU)
// compete for the port. Ties are broken round robin against the last
// owner. Each transaction issues exactly one downstream strobe, then
// waits for the controller to go idle before acknowledging the requester.
//
// Ports
//   clk, rst_x                 system clock, asynchronous active-low reset
//   ifu_req/addr -> ifu_ack/rdata            fetch request / completion
//   lsu_req/we/addr/wdata/mask -> lsu_ack/rdata  load/store request / completion
//   c_rd_en/c_wr_en/c_addr/c_wdata/c_mask    cache controller command
//   c_rdata, c_busy                          cache controller response
//   o_grant                                  current/last owner (0=IFU, 1=LSU)
//   o_timeout                                sticky wait-timeout flag
//
// Parameter
//   TIMEOUT  number of busy WAIT cycles that trips o_timeout (1..65535).
//            The flag sets on the clock edge that ends the TIMEOUT-th busy
//            WAIT cycle of a transaction.

module cache_port_arb #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_x,

    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ack,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_mask,
    output logic        lsu_ack,
    output logic [31:0] lsu_rdata,

    output logic        c_rd_en,
    output logic        c_wr_en,
    output logic [31:0] c_addr,
    output logic [31:0] c_wdata,
    output logic [3:0]  c_mask,
    input  logic [31:0] c_rdata,
    input  logic        c_busy,

    output logic        o_grant,
    output logic        o_timeout
);

    // state | meaning
    // IDLE  | no transaction; arbitrate between eligible requesters
    // ISSUE | one-cycle downstream strobe; capture c_rdata as hit data
    // WAIT  | wait for c_busy low, count busy cycles for the timeout
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] hit_q, hit_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic        ifu_ack_q, ifu_ack_d;
    logic        lsu_ack_q, lsu_ack_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;

    logic        ifu_elig;
    logic        lsu_elig;
    logic        pick_lsu;
    logic        null_store;
    logic [31:0] done_data;

    // A requester whose ack is high this cycle is still holding req for the
    // transaction that just finished, so it must not be granted again.
    assign ifu_elig = ifu_req & ~ifu_ack_q;
    assign lsu_elig = lsu_req & ~lsu_ack_q;
    assign pick_lsu = lsu_elig & (~ifu_elig | ~grant_q);

    assign null_store = we_q & (mask_q == 4'b0000);

    // The counter only advances on busy WAIT cycles and saturates at
    // TIMEOUT >= 1, so zero identifies the first WAIT cycle: a hit.
    assign done_data = (cnt_q == 16'd0) ? hit_q : c_rdata;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            hit_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
            ifu_ack_q   <= 1'b0;
            lsu_ack_q   <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            hit_q       <= hit_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            ifu_ack_q   <= ifu_ack_d;
            lsu_ack_q   <= lsu_ack_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        hit_d       = hit_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        ifu_ack_d   = 1'b0;
        lsu_ack_d   = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        c_rd_en     = 1'b0;
        c_wr_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ifu_elig || lsu_elig) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_lsu;
                    if (pick_lsu) begin
                        addr_d  = lsu_addr;
                        we_d    = lsu_we;
                        wdata_d = lsu_wdata;
                        mask_d  = lsu_mask;
                    end else begin
                        addr_d  = ifu_addr;
                        we_d    = 1'b0;
                    end
                end
            end

            ST_ISSUE: begin
                hit_d = c_rdata;
                cnt_d = '0;
                if (null_store) begin
                    // Nothing to write: finish without touching the cache.
                    state_d   = ST_IDLE;
                    lsu_ack_d = 1'b1;
                end else begin
                    c_rd_en = ~we_q;
                    c_wr_en = we_q;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!c_busy) begin
                    state_d = ST_IDLE;
                    if (grant_q) begin
                        lsu_ack_d   = 1'b1;
                        lsu_rdata_d = done_data;
                    end else begin
                        ifu_ack_d   = 1'b1;
                        ifu_rdata_d = done_data;
                    end
                end else if (cnt_q != TMO) begin
                    cnt_d = cnt_q + 16'd1;
                    if ((cnt_q + 16'd1) == TMO) begin
                        tmo_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ifu_ack   = ifu_ack_q;
    assign lsu_ack   = lsu_ack_q;
    assign ifu_rdata = ifu_rdata_q;
    assign lsu_rdata = lsu_rdata_q;
    assign c_addr    = addr_q;
    assign c_wdata   = wdata_q;
    assign c_mask    = mask_q;
    assign o_grant   = grant_q;
    assign o_timeout = tmo_q;

endmodule

// File: tb/tb_cache_port_arb.sv
// Testbench for cache_port_arb. The bench plays both requesters and the
// cache controller. A transaction-level model predicts, from the grant
// cycle and the busy length it chooses for the controller, when each ack
// must appear and which data it must carry.

module tb_cache_port_arb;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_ack;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_mask = '0;
    logic        lsu_ack;
    logic [31:0] lsu_rdata;
    logic        c_rd_en;
    logic        c_wr_en;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_mask;
    logic [31:0] c_rdata = '0;
    logic        c_busy = 1'b0;
    logic        o_grant;
    logic        o_timeout;

    cache_port_arb #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst_x     (rst_x),
        .ifu_req   (ifu_req),
        .ifu_addr  (ifu_addr),
        .ifu_ack   (ifu_ack),
        .ifu_rdata (ifu_rdata),
        .lsu_req   (lsu_req),
        .lsu_we    (lsu_we),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_mask  (lsu_mask),
        .lsu_ack   (lsu_ack),
        .lsu_rdata (lsu_rdata),
        .c_rd_en   (c_rd_en),
        .c_wr_en   (c_wr_en),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_mask    (c_mask),
        .c_rdata   (c_rdata),
        .c_busy    (c_busy),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // requester side of the model (index 0 = IFU, 1 = LSU)
    bit          rq_req [2];
    bit          rq_st  [2];
    bit          rq_gnt [2];
    logic [31:0] rq_addr[2];
    bit          l_we;
    logic [31:0] l_wdata;
    logic [3:0]  l_mask;

    // the single transaction in flight
    bit          t_v;
    int          t_s, t_a, t_b, t_own;
    bit          t_rd, t_st, t_null;
    logic [31:0] t_addr, t_wdata, t_hit, t_ref;
    logic [3:0]  t_mask;

    bit          last_own;
    int          tmo_cyc;
    int          n_gnt;

    // knobs
    int          rq_prob;
    int          drop_prob;
    bit          mask0_en;
    int          force_b;
    bit          force_val;
    logic [31:0] f_hit, f_ref;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        t_v       = 1'b0;
        last_own  = 1'b1;
        tmo_cyc   = 32'h3fff_ffff;
        for (int r = 0; r < 2; r++) begin
            rq_req[r]  = 1'b0;
            rq_st[r]   = 1'b0;
            rq_gnt[r]  = 1'b0;
            rq_addr[r] = '0;
        end
        l_we = 1'b0; l_wdata = '0; l_mask = '0;
    endtask

    task automatic issue(input int r, input logic [31:0] a, input bit we,
                         input logic [31:0] wd, input logic [3:0] m);
        rq_st[r]   = 1'b1;
        rq_req[r]  = 1'b1;
        rq_addr[r] = a;
        if (r == 1) begin
            l_we = we; l_wdata = wd; l_mask = m;
        end
    endtask

    task automatic step();
        int  k;
        bit  ack_now[2];
        bit  e0, e1, own;
        @(negedge clk);
        k = cyc;
        for (int r = 0; r < 2; r++) ack_now[r] = t_v && (k == t_a) && (t_own == r);

        // outputs of cycle k
        chk_eq("ifu_ack", ifu_ack, ack_now[0]);
        chk_eq("lsu_ack", lsu_ack, ack_now[1]);
        if (t_v && k == t_a && t_rd)
            chk_eq(t_own == 0 ? "ifu_rdata" : "lsu_rdata",
                   t_own == 0 ? ifu_rdata : lsu_rdata,
                   (t_b == 0) ? t_hit : t_ref);
        chk_eq("c_rd_en", c_rd_en, t_v && k == t_s + 1 && t_rd);
        chk_eq("c_wr_en", c_wr_en, t_v && k == t_s + 1 && t_st && !t_null);
        if (t_v && k > t_s && k <= t_a) chk_eq("c_addr", c_addr, t_addr);
        if (t_v && k == t_s + 1 && t_st && !t_null) begin
            chk_eq("c_wdata", c_wdata, t_wdata);
            chk_eq("c_mask", c_mask, t_mask);
        end
        chk_eq("o_grant", o_grant, last_own);
        chk_eq("o_timeout", o_timeout, k >= tmo_cyc);

        for (int r = 0; r < 2; r++)
            if (ack_now[r]) begin rq_st[r] = 1'b0; rq_gnt[r] = 1'b0; end

        // requesters
        for (int r = 0; r < 2; r++) begin
            if (ack_now[r]) begin
                // still holding req in the ack cycle
            end else if (!rq_st[r]) begin
                if (int'($urandom_range(0, 99)) < rq_prob) begin
                    rq_st[r]   = 1'b1;
                    rq_req[r]  = 1'b1;
                    rq_addr[r] = $urandom;
                    if (r == 1) begin
                        l_we    = $urandom_range(0, 1);
                        l_wdata = $urandom;
                        l_mask  = 4'($urandom);
                        if (!mask0_en && l_mask == 4'b0000) l_mask = 4'hF;
                    end
                end else begin
                    rq_req[r] = 1'b0;
                end
            end else if (rq_gnt[r] && rq_req[r] && int'($urandom_range(0, 99)) < drop_prob) begin
                rq_req[r]  = 1'b0;
                rq_addr[r] = $urandom;
                if (r == 1) begin
                    l_we = ~l_we; l_wdata = $urandom; l_mask = 4'($urandom);
                end
            end
        end
        ifu_req   = rq_req[0];
        ifu_addr  = rq_addr[0];
        lsu_req   = rq_req[1];
        lsu_addr  = rq_addr[1];
        lsu_we    = l_we;
        lsu_wdata = l_wdata;
        lsu_mask  = l_mask;

        // cache controller response for cycle k
        if (t_v && !t_null && k == t_s + 1) begin
            c_busy = 1'b0; c_rdata = t_hit;
        end else if (t_v && !t_null && k >= t_s + 2 && k <= t_s + 1 + t_b) begin
            c_busy = 1'b1; c_rdata = $urandom;
        end else if (t_v && !t_null && t_b > 0 && k == t_s + 2 + t_b) begin
            c_busy = 1'b0; c_rdata = t_ref;
        end else begin
            c_busy = 1'b0; c_rdata = $urandom;
        end

        // arbitration at the end of cycle k
        if (!t_v || k >= t_a) begin
            e0 = rq_req[0] && !ack_now[0];
            e1 = rq_req[1] && !ack_now[1];
            if (e0 || e1) begin
                own     = (e0 && e1) ? !last_own : e1;
                t_v     = 1'b1;
                t_s     = k;
                t_own   = own;
                t_addr  = rq_addr[own];
                t_rd    = !own || !l_we;
                t_st    = own && l_we;
                t_wdata = l_wdata;
                t_mask  = l_mask;
                t_null  = t_st && (l_mask == 4'b0000);
                t_hit   = force_val ? f_hit : $urandom;
                t_ref   = force_val ? f_ref : $urandom;
                if (t_null)            t_b = 0;
                else if (force_b >= 0) t_b = force_b;
                else if (t_rd)         t_b = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
                else                   t_b = $urandom_range(1, 6);
                t_a = t_null ? k + 2 : k + 3 + t_b;
                if (!t_null && t_b >= T && k + 2 + T < tmo_cyc) tmo_cyc = k + 2 + T;
                last_own = own;
                rq_gnt[own] = 1'b1;
                n_gnt++;
            end
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((rq_st[0] || rq_st[1]) && n < maxc) begin
            step();
            n++;
        end
        chk_eq("drain_bound", rq_st[0] || rq_st[1], 1'b0);
        repeat (2) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_x = 1'b0;
        #1;
        chk_eq("rst_ifu_ack", ifu_ack, 1'b0);
        chk_eq("rst_lsu_ack", lsu_ack, 1'b0);
        chk_eq("rst_c_rd_en", c_rd_en, 1'b0);
        chk_eq("rst_c_wr_en", c_wr_en, 1'b0);
        chk_eq("rst_o_timeout", o_timeout, 1'b0);
        chk_eq("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk_eq("rst_lsu_rdata", lsu_rdata, 32'h0);
        chk_eq("rst_c_addr", c_addr, 32'h0);
        chk_eq("rst_c_wdata", c_wdata, 32'h0);
        chk_eq("rst_c_mask", c_mask, 32'h0);
        chk_eq("rst_o_grant", o_grant, 1'b1);
        model_reset();
        ifu_req = 1'b0; lsu_req = 1'b0; c_busy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_eq("rst_hold_ifu_ack", ifu_ack, 1'b0);
            chk_eq("rst_hold_lsu_ack", lsu_ack, 1'b0);
            chk_eq("rst_hold_c_rd_en", c_rd_en, 1'b0);
        end
        rst_x = 1'b1;
    endtask

    initial begin
        int guard;
        rq_prob = 0; drop_prob = 0; mask0_en = 1'b0;
        force_b = -1; force_val = 1'b0; f_hit = '0; f_ref = '0;
        n_gnt = 0;
        model_reset();
        do_reset();

        // round robin: both request continuously from reset
        force_b = 0; rq_prob = 100; n_gnt = 0; guard = 0;
        while (n_gnt < 16 && guard < 300) begin
            step();
            guard++;
        end
        chk_eq("rr_bound", n_gnt >= 16, 1'b1);
        rq_prob = 0;
        drain(100);

        // IFU read hit
        force_b = 0; force_val = 1'b1; f_hit = 32'hDEADBEEF; f_ref = 32'h0;
        issue(0, 32'h100, 1'b0, '0, '0);
        drain(50);

        // LSU load miss, 20 busy cycles
        do_reset();
        force_b = 20; f_hit = 32'h0BAD0BAD; f_ref = 32'h12345678;
        issue(1, 32'h200, 1'b0, '0, '0);
        drain(60);

        // stores: hit, miss, and an empty mask
        do_reset();
        force_val = 1'b0;
        force_b = 1;
        issue(1, 32'h300, 1'b1, 32'hAABBCCDD, 4'b0011);
        drain(50);
        force_b = 4;
        issue(1, 32'h304, 1'b1, 32'h01020304, 4'b1100);
        drain(50);
        force_b = -1;
        issue(1, 32'h308, 1'b1, 32'h55667788, 4'b0000);
        drain(50);

        // timeout: 7 busy cycles stay clear, 10 trip the sticky flag
        force_b = 7;
        issue(0, 32'h400, 1'b0, '0, '0);
        drain(50);
        force_b = 10;
        issue(0, 32'h404, 1'b0, '0, '0);
        drain(50);
        force_b = 0;
        issue(1, 32'h408, 1'b0, '0, '0);
        drain(50);

        // reset in the middle of WAIT, then a fresh fetch
        force_b = 10;
        issue(0, 32'h500, 1'b0, '0, '0);
        repeat (6) step();
        do_reset();
        force_b = 0;
        issue(0, 32'h504, 1'b0, '0, '0);
        drain(50);

        // randomized traffic
        do_reset();
        force_b = -1; rq_prob = 35; drop_prob = 10; mask0_en = 1'b1;
        repeat (3000) step();
        rq_prob = 0;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_port_arb.md
CACHE_PORT_ARB -- requirements
Module: cache_port_arb

Interface
REQ-001 Parameter: TIMEOUT, default 4096, WAIT-cycle count at which o_timeout sets (range 1..65535).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_x  input  1  asynchronous, active-low reset.
REQ-004 ifu_req  input  1  fetch read request; held high until ifu_ack.
REQ-005 ifu_addr  input  32  fetch byte address.
REQ-006 ifu_ack  output  1  one-cycle completion pulse for fetch.
REQ-007 ifu_rdata  output  32  fetch data, valid while ifu_ack=1.
REQ-008 lsu_req  input  1  load/store request; held high until lsu_ack.
REQ-009 lsu_we  input  1  1=store, 0=load.
REQ-010 lsu_addr  input  32  load/store byte address.
REQ-011 lsu_wdata  input  32  store data.
REQ-012 lsu_mask  input  4  store byte enables.
REQ-013 lsu_ack  output  1  one-cycle completion pulse for load/store.
REQ-014 lsu_rdata  output  32  load data, valid while lsu_ack=1.
REQ-015 c_rd_en  output  1  cache controller read strobe.
REQ-016 c_wr_en  output  1  cache controller write strobe.
REQ-017 c_addr  output  32  cache controller address.
REQ-018 c_wdata  output  32  cache controller write data.
REQ-019 c_mask  output  4  cache controller byte mask.
REQ-020 c_rdata  input  32  cache controller read data.
REQ-021 c_busy  input  1  cache controller busy (registered, rises one cycle after a miss or write is sampled).
REQ-022 o_grant  output  1  current/last owner: 0=IFU, 1=LSU.
REQ-023 o_timeout  output  1  sticky: a transaction exceeded TIMEOUT WAIT cycles.

Function
REQ-024 FSM states IDLE, ISSUE, WAIT; IDLE->ISSUE on grant; ISSUE->WAIT unconditionally; WAIT->IDLE on completion.
REQ-025 IDLE: eligible requester = req high and its ack not high this cycle; one eligible -> grant it; both -> grant the one not granted last (round robin).
REQ-026 On grant, latch addr (and we, wdata, mask for LSU) and set o_grant; c_addr/c_wdata/c_mask hold latched values from ISSUE until the next grant.
REQ-027 ISSUE: exactly one cycle with c_rd_en=1 (IFU, or LSU load) or c_wr_en=1 (LSU store); register c_rdata into a hit buffer at end of ISSUE.
REQ-028 c_rd_en and c_wr_en are 0 in IDLE and WAIT; never both 1.
REQ-029 WAIT first cycle, c_busy=0: read hit; complete with hit-buffer data.
REQ-030 WAIT later cycle, c_busy=0 after being 1: complete with c_rdata sampled in that cycle (miss refill data); for stores data is don't-care.
REQ-031 Completion: next cycle, granted ack=1 for exactly one cycle with rdata valid; state returns to IDLE in the same cycle.
REQ-032 Latency: read hit, ack 3 cycles after the IDLE cycle that sampled req; store hit, 4 cycles; misses, 2 cycles after c_busy falls.
REQ-033 LSU store with lsu_mask=4'b0000: no downstream strobe; IDLE->ISSUE->IDLE, lsu_ack pulses in cycle after ISSUE.
REQ-034 Requester dropping req before ack: transaction still completes on latched values; ack still pulses.
REQ-035 WAIT counter clears on entering WAIT, increments per WAIT cycle, saturates at TIMEOUT; reaching TIMEOUT sets o_timeout; transaction still waits for c_busy=0.
REQ-036 Requests arriving while not in IDLE wait; no queueing beyond the req level.

Reset
REQ-037 rst_x low: state IDLE immediately; ifu_ack, lsu_ack, c_rd_en, c_wr_en, o_timeout = 0; ifu_rdata, lsu_rdata, c_addr, c_wdata, c_mask, counter = 0; o_grant=1 so IFU wins the first tie.
REQ-038 Reset mid-transaction abandons it without ack; cache controller shares rst_x.

Verification
REQ-039 Both req high in IDLE after reset -> IFU granted first, LSU next; alternation holds over 8 back-to-back pairs.
REQ-040 IFU read 0x100, cache hit returning 0xDEADBEEF in ISSUE, c_busy stays 0 -> ifu_ack 3 cycles after req sampled, ifu_rdata=0xDEADBEEF.
REQ-041 LSU load 0x200 miss, c_busy high 20 cycles then low with c_rdata=0x12345678 -> c_addr stable throughout, lsu_ack once, lsu_rdata=0x12345678.
REQ-042 LSU store 0x300, wdata 0xAABBCCDD, mask 0011 -> one c_wr_en cycle with those values; lsu_ack after c_busy falls; store mask 0000 -> no strobe, ack 2 cycles after sampling.
REQ-043 TIMEOUT=8, c_busy held 10 WAIT cycles -> o_timeout rises in WAIT cycle 8, stays 1 after completion until rst_x.
REQ-044 rst_x low during WAIT -> outputs at reset values immediately, no ack; fresh IFU request after release completes normally.
